// File: rtl/fetch_branch_ctrl_pkg.sv
// Shared constants for the fetch/branch sequencer: RV32 control-flow opcodes,
// reset PC default and the fetch FSM state encoding.
package fetch_branch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;
  localparam logic [2:0] FUNCT3_JALR = 3'b000;

  typedef enum logic [2:0] {
    FB_BOOT     = 3'd0,
    FB_REQ      = 3'd1,
    FB_WAIT_RSP = 3'd2,
    FB_HOLD     = 3'd3,
    FB_WAIT_BR  = 3'd4
  } fb_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_branch_ctrl_pre_decode.sv
// Flags conditional branches (beq..bgeu), jal and jalr in a raw instruction word.
module fetch_branch_ctrl_pre_decode
  import fetch_branch_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic        branch_inst_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_fields;

  assign opcode        = inst_i[6:0];
  assign funct3        = inst_i[14:12];
  assign unused_fields = ^{inst_i[31:15], inst_i[11:7]};

  always_comb begin
    branch_inst_o = 1'b0;
    case (opcode)
      OPCODE_BRANCH: begin
        case (funct3)
          FUNCT3_BEQ, FUNCT3_BNE, FUNCT3_BLT,
          FUNCT3_BGE, FUNCT3_BLTU, FUNCT3_BGEU: branch_inst_o = 1'b1;
          default:                              branch_inst_o = 1'b0;
        endcase
      end
      OPCODE_JAL:  branch_inst_o = 1'b1;
      OPCODE_JALR: branch_inst_o = (funct3 == FUNCT3_JALR);
      default:     branch_inst_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_branch_ctrl.sv
// Fetch-side PC sequencer: one outstanding fetch at a time, stalls after any
// control-flow instruction until execute reports the resolved next PC.
module fetch_branch_ctrl
  import fetch_branch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_inst_o,
  output logic [31:0] out_pc_o,
  input  logic        redirect_valid_i,
  input  logic        redirect_taken_i,
  input  logic [31:0] redirect_target_i,
  output logic        br_stall_o
);

  fb_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        is_br_q, is_br_d;
  logic        rsp_is_br;
  logic        unused_target_lsbs;

  assign unused_target_lsbs = ^redirect_target_i[1:0];

  fetch_branch_ctrl_pre_decode u_pre_decode (
    .inst_i        (rsp_data_i),
    .branch_inst_o (rsp_is_br)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FB_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FB_BOOT;
    case (state_q)
      FB_BOOT:     state_d = FB_REQ;
      FB_REQ:      state_d = req_ready_i ? FB_WAIT_RSP : FB_REQ;
      FB_WAIT_RSP: state_d = rsp_valid_i ? FB_HOLD : FB_WAIT_RSP;
      FB_HOLD: begin
        if (out_ready_i) begin
          state_d = is_br_q ? FB_WAIT_BR : FB_REQ;
        end else begin
          state_d = FB_HOLD;
        end
      end
      FB_WAIT_BR:  state_d = redirect_valid_i ? FB_REQ : FB_WAIT_BR;
      default:     state_d = FB_BOOT;
    endcase
  end

  always_comb begin
    req_valid_o = (state_q == FB_REQ);
    out_valid_o = (state_q == FB_HOLD);
    br_stall_o  = (state_q == FB_WAIT_BR);
  end

  // Datapath only moves on the handshakes of the state that owns it, so
  // stray pulses in other states leave pc and outputs untouched.
  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    out_pc_d = out_pc_q;
    is_br_d  = is_br_q;
    case (state_q)
      FB_WAIT_RSP: begin
        if (rsp_valid_i) begin
          inst_d   = rsp_data_i;
          out_pc_d = pc_q;
          is_br_d  = rsp_is_br;
        end
      end
      FB_HOLD: begin
        if (out_ready_i && !is_br_q) begin
          pc_d = pc_plus4(pc_q);
        end
      end
      FB_WAIT_BR: begin
        if (redirect_valid_i) begin
          pc_d = redirect_taken_i ? {redirect_target_i[31:2], 2'b00} : pc_plus4(pc_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      out_pc_q <= '0;
      is_br_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      out_pc_q <= out_pc_d;
      is_br_q  <= is_br_d;
    end
  end

  assign req_addr_o = pc_q;
  assign out_inst_o = inst_q;
  assign out_pc_o   = out_pc_q;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Transaction-level bench: acts as instruction memory, decode and execute,
// predicting the PC stream from the control-flow rules.
module tb_fetch_branch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        redirect_valid_i = 1'b0;
  logic        redirect_taken_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic        br_stall_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn = 0;
  logic [31:0] exp_pc;

  fetch_branch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid_o       (req_valid_o),
    .req_ready_i       (req_ready_i),
    .req_addr_o        (req_addr_o),
    .rsp_valid_i       (rsp_valid_i),
    .rsp_data_i        (rsp_data_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_inst_o        (out_inst_o),
    .out_pc_o          (out_pc_o),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_taken_i  (redirect_taken_i),
    .redirect_target_i (redirect_target_i),
    .br_stall_o        (br_stall_o)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Control-flow classification straight from the ISA opcode map.
  function automatic bit ref_is_branch(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    if (w[6:0] == 7'h63) return (f3 != 3'd2) && (f3 != 3'd3);
    if (w[6:0] == 7'h6F) return 1'b1;
    if (w[6:0] == 7'h67) return (f3 == 3'd0);
    return 1'b0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_valid"}, {31'b0, req_valid_o}, 32'd0);
    check_val({tag, "_out_valid"}, {31'b0, out_valid_o}, 32'd0);
    check_val({tag, "_br_stall"}, {31'b0, br_stall_o}, 32'd0);
    check_val({tag, "_out_inst"}, out_inst_o, 32'd0);
    check_val({tag, "_out_pc"}, out_pc_o, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    exp_pc = RST_PC;
    check_val("boot_idle", {31'b0, req_valid_o}, 32'd0);
    @(negedge clock);
    check_val("boot_to_req", {31'b0, req_valid_o}, 32'd1);
  endtask

  // One full fetch: request, response, decode handshake and, for branches,
  // the redirect. If abort_br is set, reset is pulsed while stalled instead.
  task automatic fetch_one(input logic [31:0] inst, input int req_dly, input int rsp_lat,
                           input int out_dly, input int br_dly, input bit taken,
                           input logic [31:0] target, input bit spurious, input bit abort_br);
    bit          isbr;
    int          guard;
    logic [31:0] pc_at;
    isbr  = ref_is_branch(inst);
    guard = 0;
    while (req_valid_o !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check_val("req_valid", {31'b0, req_valid_o}, 32'd1);
    check_val("req_addr", req_addr_o, exp_pc);
    pc_at = exp_pc;
    for (int i = 0; i < req_dly; i++) begin
      redirect_valid_i  = spurious;
      redirect_taken_i  = 1'b1;
      redirect_target_i = $urandom;
      @(negedge clock);
      redirect_valid_i = 1'b0;
      check_val("req_hold_valid", {31'b0, req_valid_o}, 32'd1);
      check_val("req_hold_addr", req_addr_o, pc_at);
    end
    req_ready_i = 1'b1;
    @(negedge clock);
    req_ready_i = 1'b0;
    check_val("no_dup_req", {31'b0, req_valid_o}, 32'd0);
    for (int i = 0; i < rsp_lat; i++) begin
      redirect_valid_i  = spurious;
      redirect_target_i = $urandom;
      @(negedge clock);
      redirect_valid_i = 1'b0;
      check_val("wait_no_req", {31'b0, req_valid_o}, 32'd0);
      check_val("wait_no_out", {31'b0, out_valid_o}, 32'd0);
    end
    rsp_valid_i = 1'b1;
    rsp_data_i  = inst;
    @(negedge clock);
    rsp_valid_i = 1'b0;
    rsp_data_i  = $urandom;
    check_val("out_valid", {31'b0, out_valid_o}, 32'd1);
    check_val("out_inst", out_inst_o, inst);
    check_val("out_pc", out_pc_o, pc_at);
    for (int i = 0; i < out_dly; i++) begin
      rsp_valid_i      = spurious;
      rsp_data_i       = $urandom;
      redirect_valid_i = spurious;
      @(negedge clock);
      rsp_valid_i      = 1'b0;
      redirect_valid_i = 1'b0;
      check_val("out_hold_valid", {31'b0, out_valid_o}, 32'd1);
      check_val("out_hold_inst", out_inst_o, inst);
      check_val("out_hold_pc", out_pc_o, pc_at);
    end
    out_ready_i = 1'b1;
    if (isbr && spurious) begin
      redirect_valid_i  = 1'b1;
      redirect_taken_i  = 1'b1;
      redirect_target_i = $urandom;
    end
    @(negedge clock);
    out_ready_i      = 1'b0;
    redirect_valid_i = 1'b0;
    check_val("out_dropped", {31'b0, out_valid_o}, 32'd0);
    check_val("br_stall", {31'b0, br_stall_o}, {31'b0, isbr});
    if (isbr) begin
      check_val("stall_no_req", {31'b0, req_valid_o}, 32'd0);
      for (int i = 0; i < br_dly; i++) begin
        @(negedge clock);
        check_val("stall_hold", {31'b0, br_stall_o}, 32'd1);
        check_val("stall_hold_no_req", {31'b0, req_valid_o}, 32'd0);
      end
      if (abort_br) begin
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_in_br");
        release_reset();
      end else begin
        redirect_valid_i  = 1'b1;
        redirect_taken_i  = taken;
        redirect_target_i = target;
        @(negedge clock);
        redirect_valid_i  = 1'b0;
        exp_pc = taken ? {target[31:2], 2'b00} : exp_pc + 32'd4;
      end
    end else begin
      exp_pc = exp_pc + 32'd4;
    end
    n_txn++;
    $display("txn %0d pc=%h inst=%h br=%0d taken=%0d next=%h", n_txn, pc_at, inst, isbr,
             taken, exp_pc);
  endtask

  initial begin
    logic [31:0] w;
    exp_pc = RST_PC;
    #12;
    check_reset_outputs("reset");
    release_reset();

    fetch_one(32'h0000_0013, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch_one(32'h0080_006F, 0, 1, 0, 3, 1'b1, 32'h8000_0008, 1'b0, 1'b0);
    fetch_one(32'h0020_8463, 1, 0, 1, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch_one(32'h0020_8463, 0, 2, 0, 1, 1'b1, 32'h8000_0102, 1'b0, 1'b0);
    fetch_one(32'h0000_0013, 3, 2, 5, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch_one(32'h0000_0013, 2, 2, 3, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    fetch_one(32'h0000_8067, 0, 1, 1, 2, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    fetch_one(32'h0000_0013, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch_one(32'h0000_0013, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch_one(32'h0020_9463, 0, 1, 0, 2, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
    fetch_one(32'h0000_0013, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      w = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: w[6:0] = 7'h63;
        4, 5:       w[6:0] = 7'h6F;
        6:          w[6:0] = 7'h67;
        default:    ;
      endcase
      fetch_one(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion within 200000 time units");
    $fatal(1, "bench timeout");
  end

endmodule
